// File: rtl/ether_pkg.sv
// Shared Ethernet header geometry and receive-filter FSM state encoding.
// Latency: none (constants and types only).
// Backpressure: none (constants and types only).
//
// Contents: header field widths in bits, the broadcast MAC, and the
// filter FSM state type.
package ether_pkg;

  localparam int ETH_DEST_BITS = 48;
  localparam int ETH_SRC_BITS  = 48;
  localparam int ETH_TYPE_BITS = 16;
  localparam int ETH_HDR_BITS  = ETH_DEST_BITS + ETH_SRC_BITS + ETH_TYPE_BITS;

  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEST    = 3'd1,
    SRC     = 3'd2,
    TYPE    = 3'd3,
    PAYLOAD = 3'd4,
    DROP    = 3'd5
  } eth_state_e;

endpackage

// File: rtl/ether_field_match.sv
// Sticky per-beat comparator of one header field against a constant value.
// Latency: match is combinational and already includes the beat presented this cycle.
// Backpressure: none; one beat is consumed every cycle en is high.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      first beat of a new frame: forget any earlier mismatch
//   en         din carries beat beat_idx of this field
//   beat_idx   beat number within the field, 0 = most significant DW bits
//   din        beat data
//   match      every beat of this field seen so far in the frame matched VALUE
module ether_field_match #(
  parameter int                    DW         = 2,
  parameter int                    FIELD_BITS = 48,
  parameter logic [FIELD_BITS-1:0] VALUE      = '0,
  parameter int                    IDX_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [IDX_W-1:0] beat_idx,
  input  logic [DW-1:0]    din,
  output logic             match
);

  logic                  match_q;
  logic                  match_d;
  logic [FIELD_BITS-1:0] shifted;
  logic [DW-1:0]         exp_beat;
  int                    shamt;

  always_comb begin
    // Shift the wanted beat up to the top of the field so a constant
    // part-select picks it out, MSB-first.
    shamt    = int'(beat_idx) * DW;
    shifted  = VALUE << shamt;
    exp_beat = shifted[FIELD_BITS-1 -: DW];
    match_d  = start ? 1'b1 : match_q;
    if (en && (din != exp_beat)) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b1;
    end else begin
      match_q <= match_d;
    end
  end

  // The FSM decides on the last TYPE beat, so it needs that beat folded in.
  assign match = match_d;

endmodule

// File: rtl/ether_rx_filter.sv
// Receive Ethernet frame filter: passes payload of frames addressed to us (or broadcast), optionally EtherType-gated.
// Latency: 1 cycle input to output; first payload beat leaves one cycle after header beat HDR arrives.
// Backpressure: none; the stream cannot be stalled, frames that fail the filter are discarded.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   axiiv, axiid   input beat stream, valid high for the whole frame, MSB-first fields
//   axiov, axiod   payload beats of accepted frames (axiod is 0 while axiov is 0)
//   accept_count   accepted frames, saturating
//   drop_count     dropped frames including runts, saturating
// Build option ETHER_RX_FILTER_STATS_EN: when defined the two counters are
// live; otherwise they are tied to zero and no counter logic exists.
module ether_rx_filter
  import ether_pkg::*;
#(
  parameter int          DW         = 2,
  parameter logic [47:0] FPGA_MAC   = 48'h0,
  parameter logic [15:0] ETHERTYPE  = 16'h0,
  parameter bit          CHECK_TYPE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          axiiv,
  input  logic [DW-1:0] axiid,
  output logic          axiov,
  output logic [DW-1:0] axiod,
  output logic [15:0]   accept_count,
  output logic [15:0]   drop_count
);

  localparam int DEST_BEATS = ETH_DEST_BITS / DW;
  localparam int SRC_BEATS  = ETH_SRC_BITS / DW;
  localparam int HDR_BEATS  = ETH_HDR_BITS / DW;
  localparam int CNT_W      = $clog2(HDR_BEATS + 1);

  localparam logic [CNT_W-1:0] DEST_LAST  = CNT_W'(DEST_BEATS - 1);
  localparam logic [CNT_W-1:0] SRC_LAST   = CNT_W'(DEST_BEATS + SRC_BEATS - 1);
  localparam logic [CNT_W-1:0] TYPE_FIRST = CNT_W'(DEST_BEATS + SRC_BEATS);
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BEATS - 1);

  if (!(DW == 2 || DW == 4 || DW == 8)) begin : g_bad_dw
    $error("ether_rx_filter: DW must be 2, 4 or 8");
  end

  eth_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_gap_q, wait_gap_d;
  logic             axiov_q, axiov_d;
  logic [DW-1:0]    axiod_q, axiod_d;

  logic             frame_start;
  logic             dest_en;
  logic             type_en;
  logic [CNT_W-1:0] type_idx;
  logic             me_match;
  logic             bcast_match;
  logic             type_match;
  logic             accept_evt;
  logic             drop_evt;

  // Beat 0 of the destination arrives while still in IDLE, so the
  // destination comparators start and compare on that same cycle.
  // wait_gap blocks a new frame from starting in the tail of a frame
  // that was cut short by rst.
  assign frame_start = axiiv && (state_q == IDLE) && !wait_gap_q;
  assign dest_en     = frame_start || (axiiv && (state_q == DEST));
  assign type_en     = axiiv && (state_q == TYPE);
  assign type_idx    = cnt_q - TYPE_FIRST;

  ether_field_match #(
    .DW(DW), .FIELD_BITS(ETH_DEST_BITS), .VALUE(FPGA_MAC), .IDX_W(CNT_W)
  ) u_me_match (
    .clk(clk), .rst(rst), .start(frame_start), .en(dest_en),
    .beat_idx(cnt_q), .din(axiid), .match(me_match)
  );

  ether_field_match #(
    .DW(DW), .FIELD_BITS(ETH_DEST_BITS), .VALUE(ETH_BCAST_MAC), .IDX_W(CNT_W)
  ) u_bcast_match (
    .clk(clk), .rst(rst), .start(frame_start), .en(dest_en),
    .beat_idx(cnt_q), .din(axiid), .match(bcast_match)
  );

  ether_field_match #(
    .DW(DW), .FIELD_BITS(ETH_TYPE_BITS), .VALUE(ETHERTYPE), .IDX_W(CNT_W)
  ) u_type_match (
    .clk(clk), .rst(rst), .start(frame_start), .en(type_en),
    .beat_idx(type_idx), .din(axiid), .match(type_match)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_gap_d = wait_gap_q;
    axiov_d    = 1'b0;
    axiod_d    = '0;
    accept_evt = 1'b0;
    drop_evt   = 1'b0;

    if (!axiiv) begin
      // Frame gap: always back to IDLE; a frame ending inside the header is a runt.
      state_d    = IDLE;
      cnt_d      = '0;
      wait_gap_d = 1'b0;
      if (state_q inside {DEST, SRC, TYPE}) begin
        drop_evt = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!wait_gap_q) begin
            state_d = DEST;
            cnt_d   = CNT_W'(1);
          end
        end
        DEST: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DEST_LAST) begin
            state_d = SRC;
          end
        end
        SRC: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == SRC_LAST) begin
            state_d = TYPE;
          end
        end
        TYPE: begin
          // On the last header beat the counter reaches HDR_BEATS and then
          // holds there for the rest of the frame.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == HDR_LAST) begin
            if ((me_match || bcast_match) && (type_match || !CHECK_TYPE)) begin
              state_d    = PAYLOAD;
              accept_evt = 1'b1;
            end else begin
              state_d  = DROP;
              drop_evt = 1'b1;
            end
          end
        end
        PAYLOAD: begin
          axiov_d = 1'b1;
          axiod_d = axiid;
        end
        DROP: begin
          state_d = DROP;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      // Reset in the middle of a frame: ignore the rest of it.
      wait_gap_q <= axiiv;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_gap_q <= wait_gap_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
    end
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;

`ifdef ETHER_RX_FILTER_STATS_EN
  logic [15:0] accept_cnt_q, accept_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    accept_cnt_d = accept_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (accept_evt && (accept_cnt_q != 16'hFFFF)) begin
      accept_cnt_d = accept_cnt_q + 16'd1;
    end
    if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt_q <= 16'h0000;
      drop_cnt_q   <= 16'h0000;
    end else begin
      accept_cnt_q <= accept_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign accept_count = accept_cnt_q;
  assign drop_count   = drop_cnt_q;
`else
  logic stats_evt_unused;
  assign stats_evt_unused = accept_evt ^ drop_evt;
  assign accept_count     = 16'h0000;
  assign drop_count       = 16'h0000;
`endif

endmodule

// File: tb/tb_ether_rx_filter.sv
// Bench for ether_rx_filter: three instances (DW=2 type-checked, DW=2 any type, DW=8 type-checked).
// Latency: output timing checked one cycle after header beat HDR.
// Backpressure: none on the DUT; the bench drives the stream freely.
module tb_ether_rx_filter;

  localparam logic [47:0] MAC   = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ET    = 16'h1234;
`ifdef ETHER_RX_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, iv2, iv8;
  logic [1:0] id2;
  logic [7:0] id8;
  logic       ov2, ov2n, ov8;
  logic [1:0] od2, od2n;
  logic [7:0] od8;
  logic [15:0] acc2, drp2, acc2n, drp2n, acc8, drp8;

  ether_rx_filter #(.DW(2), .FPGA_MAC(MAC), .ETHERTYPE(ET), .CHECK_TYPE(1'b1)) u2 (
    .clk(clk), .rst(rst), .axiiv(iv2), .axiid(id2), .axiov(ov2), .axiod(od2),
    .accept_count(acc2), .drop_count(drp2));
  ether_rx_filter #(.DW(2), .FPGA_MAC(MAC), .ETHERTYPE(ET), .CHECK_TYPE(1'b0)) u2n (
    .clk(clk), .rst(rst), .axiiv(iv2), .axiid(id2), .axiov(ov2n), .axiod(od2n),
    .accept_count(acc2n), .drop_count(drp2n));
  ether_rx_filter #(.DW(8), .FPGA_MAC(MAC), .ETHERTYPE(ET), .CHECK_TYPE(1'b1)) u8 (
    .clk(clk), .rst(rst), .axiiv(iv8), .axiid(id8), .axiov(ov8), .axiod(od8),
    .accept_count(acc8), .drop_count(drp8));

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit mon_en = 1'b0;
  int zviol = 0;
  int first [3];
  int extra [3];
  int derr [3];
  int macc [3];
  int mdrp [3];
  logic [7:0] fr [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic [7:0] exp2 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Beat k of the current frame, DW bits taken MSB-first from the byte stream.
  function automatic logic [7:0] get_beat(input int k, input int dw);
    logic [7:0] v;
    logic [7:0] by;
    int b;
    v = 8'h00;
    for (int i = 0; i < dw; i++) begin
      b  = k * dw + i;
      by = fr[b / 8];
      v  = {v[6:0], by[7 - (b % 8)]};
    end
    return v;
  endfunction

  function automatic int exp_size(input int inst);
    case (inst)
      0: return exp0.size();
      1: return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  task automatic push_exp(input int inst, input logic [7:0] b);
    case (inst)
      0: exp0.push_back(b);
      1: exp1.push_back(b);
      default: exp2.push_back(b);
    endcase
  endtask

  // Reference: a frame shorter than the header is a runt; otherwise it is
  // accepted when the destination is ours or broadcast and (if checked) the
  // EtherType matches, and every beat after the header comes out in order.
  task automatic model(input int inst, input int nb, input int rst_at);
    int dw, hdr, last;
    bit ct, acc;
    logic [47:0] d;
    logic [15:0] t;
    dw  = (inst == 2) ? 8 : 2;
    ct  = (inst != 1);
    hdr = 112 / dw;
    if (nb < hdr) begin
      mdrp[inst]++;
      return;
    end
    d   = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
    t   = {fr[12], fr[13]};
    acc = ((d == MAC) || (d == BCAST)) && (!ct || (t == ET));
    if (!acc) begin
      mdrp[inst]++;
      return;
    end
    macc[inst]++;
    last = (rst_at >= 0 && rst_at < nb) ? rst_at : nb;
    for (int k = hdr; k < last; k++) push_exp(inst, get_beat(k, dw));
  endtask

  task automatic mon(input int inst, input logic v, input logic [7:0] d);
    logic [7:0] e;
    if (!v) begin
      if (d !== 8'h00) zviol++;
      return;
    end
    if (first[inst] < 0) first[inst] = cyc;
    if (exp_size(inst) == 0) begin
      extra[inst]++;
      return;
    end
    case (inst)
      0: e = exp0.pop_front();
      1: e = exp1.pop_front();
      default: e = exp2.pop_front();
    endcase
    if (d !== e) derr[inst]++;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, ov2, {6'b0, od2});
      mon(1, ov2n, {6'b0, od2n});
      mon(2, ov8, od8);
    end
  end

  task automatic mk_frame(input logic [47:0] d, input logic [15:0] t, input int plen);
    fr.delete();
    for (int i = 5; i >= 0; i--) fr.push_back(d[i*8 +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom()));
    fr.push_back(t[15:8]);
    fr.push_back(t[7:0]);
    for (int i = 0; i < plen; i++) fr.push_back(8'($urandom()));
  endtask

  // Drive nb beats on bus 0 (DW=2) or bus 1 (DW=8); rst is high during beat rst_at.
  task automatic send(input int bus, input int nb, input int rst_at);
    logic [7:0] beat;
    for (int k = 0; k < nb; k++) begin
      @(posedge clk); #1;
      if (k == 0) start_cyc = cyc;
      beat = get_beat(k, bus ? 8 : 2);
      if (bus != 0) begin iv8 = 1'b1; id8 = beat; end
      else begin iv2 = 1'b1; id2 = beat[1:0]; end
      rst = (k == rst_at);
    end
    @(posedge clk); #1;
    iv2 = 1'b0; id2 = 2'b0; iv8 = 1'b0; id8 = 8'h0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int inst, input string tag);
    logic [15:0] a, d;
    case (inst)
      0: begin a = acc2;  d = drp2;  end
      1: begin a = acc2n; d = drp2n; end
      default: begin a = acc8; d = drp8; end
    endcase
    check($sformatf("%s/u%0d_extra", tag, inst), extra[inst], 0);
    check($sformatf("%s/u%0d_missing", tag, inst), exp_size(inst), 0);
    check($sformatf("%s/u%0d_data", tag, inst), derr[inst], 0);
    check($sformatf("%s/u%0d_accept", tag, inst), a, STATS ? macc[inst] : 0);
    check($sformatf("%s/u%0d_drop", tag, inst), d, STATS ? mdrp[inst] : 0);
    extra[inst] = 0;
    derr[inst]  = 0;
  endtask

  task automatic rand_frame(input int bus);
    logic [47:0] d;
    logic [15:0] t;
    int dw, hdr, nb;
    dw  = bus ? 8 : 2;
    hdr = 112 / dw;
    case ($urandom_range(3))
      0: d = MAC;
      1: d = BCAST;
      2: d = MAC ^ (48'h1 << $urandom_range(47));
      default: d = {16'($urandom()), 32'($urandom())};
    endcase
    case ($urandom_range(3))
      0, 1: t = ET;
      2: t = ET ^ (16'h1 << $urandom_range(15));
      default: t = 16'($urandom());
    endcase
    mk_frame(d, t, $urandom_range(12));
    nb = fr.size() * 8 / dw;
    if ($urandom_range(3) == 0) nb = $urandom_range(hdr, 1);
    if (bus != 0) model(2, nb, -1);
    else begin model(0, nb, -1); model(1, nb, -1); end
    send(bus, nb, -1);
    repeat ($urandom_range(2)) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; iv2 = 1'b0; id2 = 2'b0; iv8 = 1'b0; id8 = 8'h0;
    for (int i = 0; i < 3; i++) begin
      first[i] = -1; extra[i] = 0; derr[i] = 0; macc[i] = 0; mdrp[i] = 0;
    end
    idle(3);
    check("rst_axiov", ov2, 1'b0);
    check("rst_axiod", od2, 2'b0);
    check("rst_accept", acc2, 16'h0);
    check("rst_drop", drp2, 16'h0);
    check("rst_axiov8", ov8, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Our MAC, type 1234, payload DEADBEEF.
    mk_frame(MAC, ET, 0);
    fr.push_back(8'hDE); fr.push_back(8'hAD); fr.push_back(8'hBE); fr.push_back(8'hEF);
    first[0] = -1;
    model(0, 72, -1); model(1, 72, -1);
    send(0, 72, -1);
    idle(4);
    check("t1_latency", first[0], start_cyc + 57);
    chk(0, "t1"); chk(1, "t1");

    // Broadcast destination.
    mk_frame(BCAST, ET, $urandom_range(10, 1));
    model(0, fr.size() * 4, -1); model(1, fr.size() * 4, -1);
    send(0, fr.size() * 4, -1);
    idle(4);
    chk(0, "t2"); chk(1, "t2");

    // Near-miss destination: never forwarded.
    mk_frame(48'h0A1B2C3D4E5E, ET, 4);
    first[0] = -1;
    model(0, 72, -1); model(1, 72, -1);
    send(0, 72, -1);
    idle(4);
    check("t3_no_axiov", first[0], -1);
    chk(0, "t3"); chk(1, "t3");

    // Wrong EtherType: dropped when checked, forwarded when not.
    mk_frame(MAC, 16'h0800, 6);
    model(0, 80, -1); model(1, 80, -1);
    send(0, 80, -1);
    idle(4);
    chk(0, "t4"); chk(1, "t4");

    // Runt ending inside SRC, one-cycle gap, then a good frame.
    mk_frame(MAC, ET, 4);
    model(0, 30, -1); model(1, 30, -1);
    send(0, 30, -1);
    model(0, 72, -1); model(1, 72, -1);
    send(0, 72, -1);
    idle(4);
    chk(0, "t5"); chk(1, "t5");

    for (int i = 0; i < 10; i++) rand_frame(0);
    idle(4);
    chk(0, "rand2"); chk(1, "rand2");

    // rst during payload beat 3.
    mk_frame(MAC, ET, 8);
    model(0, 88, 59); model(1, 88, 59);
    send(0, 88, 59);
    for (int i = 0; i < 3; i++) begin macc[i] = 0; mdrp[i] = 0; end
    idle(4);
    chk(0, "t7"); chk(1, "t7"); chk(2, "t7");

    mk_frame(MAC, ET, 5);
    model(0, 76, -1); model(1, 76, -1);
    send(0, 76, -1);
    idle(4);
    chk(0, "t7b"); chk(1, "t7b");

    // DW=8: DEADBEEF frame.
    mk_frame(MAC, ET, 0);
    fr.push_back(8'hDE); fr.push_back(8'hAD); fr.push_back(8'hBE); fr.push_back(8'hEF);
    first[2] = -1;
    model(2, 18, -1);
    send(1, 18, -1);
    idle(4);
    check("t8_latency", first[2], start_cyc + 15);
    chk(2, "t8");

    // 1600-byte frame.
    mk_frame(MAC, ET, 1586);
    model(2, 1600, -1);
    send(1, 1600, -1);
    idle(4);
    chk(2, "t9");

    for (int i = 0; i < 6; i++) rand_frame(1);
    idle(4);
    chk(2, "rand8");

    check("axiod_zero_when_idle", zviol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
